// File: rtl/mem_access_pkg.sv
// mem_access_pkg: memory-op, size, excode and state encodings shared by the memory stage
package mem_access_pkg;
  typedef enum logic [3:0] {OP_NONE, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW} mem_op_e;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  localparam logic [4:0] EX_OV = 5'h0c;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  function automatic logic is_load(input logic [3:0] op);
    return op != OP_NONE && op <= OP_LW;
  endfunction
  function automatic logic is_half(input logic [3:0] op);
    return op == OP_LH || op == OP_LHU || op == OP_SH;
  endfunction
  function automatic logic is_word(input logic [3:0] op);
    return op == OP_LW || op == OP_SW;
  endfunction
  function automatic logic [1:0] size_of(input logic [3:0] op);
    return is_word(op) ? SZ_WORD : is_half(op) ? SZ_HALF : SZ_BYTE;
  endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: store-lane replication and load lane extraction with sign/zero extension
module mem_align
  import mem_access_pkg::*;
(
  input  logic [3:0]  st_op,
  input  logic [31:0] store_data,
  input  logic [3:0]  ld_op,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign wdata = st_op == OP_SB ? {4{store_data[7:0]}} : st_op == OP_SH ? {2{store_data[15:0]}} : store_data;
  assign b = rdata[{lane, 3'b000} +: 8];
  assign h = lane[1] ? rdata[31:16] : rdata[15:0];
  always_comb begin
    load_data = ld_op == OP_LB  ? {{24{b[7]}}, b} :
                ld_op == OP_LBU ? {24'h0, b} :
                ld_op == OP_LH  ? {{16{h[15]}}, h} :
                ld_op == OP_LHU ? {16'h0, h} : rdata;
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage with alignment exceptions and a split request/response data bus
module mem_access #(
  parameter int         ADDR_W   = 32,
  parameter logic [4:0] EXC_ADEL = 5'h04,
  parameter logic [4:0] EXC_ADES = 5'h05
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exe_valid,
  input  logic [3:0]        mem_op,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [31:0]       store_data,
  input  logic              exe_cp0_ex,
  input  logic [4:0]        exe_cp0_excode,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              mem_cp0_ex,
  output logic [4:0]        mem_cp0_excode,
  output logic [ADDR_W-1:0] badvaddr,
  output logic              stall
);
  import mem_access_pkg::*;
  state_e state, state_n;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q, wdata_n, load_data;
  logic              cancel, misaligned, start, fin, done_n;
  mem_align u_align (
    .st_op(mem_op), .store_data(store_data), .ld_op(op_q), .lane(addr_q[1:0]),
    .rdata(data_rdata), .wdata(wdata_n), .load_data(load_data)
  );
  assign misaligned = (is_half(mem_op) & alu_out[0]) | (is_word(mem_op) & |alu_out[1:0]);
  assign start = state == IDLE & exe_valid & mem_op != 4'd0 & !exe_cp0_ex & !misaligned & !flush;
  assign mem_cp0_ex = exe_cp0_ex | (exe_valid & misaligned);
  assign mem_cp0_excode = exe_cp0_ex ? exe_cp0_excode : is_load(mem_op) ? EXC_ADEL : EXC_ADES;
  assign data_req = state == REQ;
  assign data_wr = op_q >= OP_SB;
  assign data_size = size_q;
  assign data_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign data_wdata = wdata_q;
  assign stall = start | state == REQ | (state == WAIT & !data_data_ok);
  // an accepted request must drain its response even when flushed; only its effects are dropped
  assign fin = data_data_ok & ((state == REQ & data_addr_ok) | state == WAIT);
  assign done_n = fin & !cancel & !flush;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? REQ : IDLE) :
              state == REQ  ? (data_addr_ok ? (data_data_ok ? IDLE : WAIT) : (flush ? IDLE : REQ)) :
              (data_data_ok ? IDLE : WAIT);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
      addr_q <= '0;
      size_q <= '0;
      wdata_q <= '0;
      cancel <= 1'b0;
      mem_rdata <= '0;
      mem_done <= 1'b0;
      badvaddr <= '0;
    end else begin
      if (start) begin
        op_q <= mem_op;
        addr_q <= alu_out;
        size_q <= size_of(mem_op);
        wdata_q <= wdata_n;
      end
      cancel <= state_n != IDLE & (cancel | flush);
      mem_done <= done_n;
      if (done_n & is_load(op_q)) mem_rdata <= load_data;
      if (exe_valid & misaligned) badvaddr <= alu_out;
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized scoreboard bench for the memory stage against a byte-level reference model
module tb_mem_access;
  logic clk = 0, rst = 1, exe_valid = 0, exe_cp0_ex = 0, flush = 0;
  logic data_addr_ok = 0, data_data_ok = 0;
  logic [3:0] mem_op = 0;
  logic [31:0] alu_out = 0, store_data = 0, data_rdata = 0;
  logic [4:0] exe_cp0_excode = 0;
  logic data_req, data_wr, mem_done, mem_cp0_ex, stall;
  logic [1:0] data_size;
  logic [31:0] data_addr, data_wdata, mem_rdata, badvaddr;
  logic [4:0] mem_cp0_excode;

  mem_access dut (
    .clk(clk), .rst(rst), .exe_valid(exe_valid), .mem_op(mem_op), .alu_out(alu_out),
    .store_data(store_data), .exe_cp0_ex(exe_cp0_ex), .exe_cp0_excode(exe_cp0_excode),
    .flush(flush), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .mem_cp0_ex(mem_cp0_ex), .mem_cp0_excode(mem_cp0_excode),
    .badvaddr(badvaddr), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {logic wr; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata;} req_t;
  req_t req_q[$];
  logic [31:0] done_q[$];
  logic [31:0] last_rd = 0, bad = 0, next_rdata = 0;
  int a_dly = 0, d_cfg = 0, d_dly = 0;
  bit pend = 0;
  int chk = 0, err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input int op);
    return op == 0 ? 0 : (op == 1 || op == 2 || op == 6) ? 1 : (op == 3 || op == 4 || op == 7) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input int op, input logic [31:0] addr, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (addr % 4))) % 256;
    h = (w >> (16 * ((addr % 4) / 2))) % 65536;
    case (op)
      1: return b >= 128 ? b - 32'd256 : b;
      2: return b;
      3: return h >= 32768 ? h - 32'd65536 : h;
      4: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input int n, input logic [31:0] sd);
    return n == 1 ? (sd % 256) * 32'h01010101 : n == 2 ? (sd % 65536) * 32'h00010001 : sd;
  endfunction

  // bus slave: addr_ok after a_dly request cycles, data_ok d_cfg cycles after acceptance (0 = same cycle)
  initial begin : bus
    forever begin
      @(posedge clk); #1;
      data_addr_ok = 0;
      data_data_ok = 0;
      data_rdata = $urandom;
      if (rst) pend = 0;
      else if (pend) begin
        d_dly--;
        if (d_dly == 0) begin data_data_ok = 1; data_rdata = next_rdata; pend = 0; end
      end else if (data_req) begin
        if (a_dly == 0) begin
          data_addr_ok = 1;
          d_dly = d_cfg;
          pend = d_cfg != 0;
          if (d_cfg == 0) begin data_data_ok = 1; data_rdata = next_rdata; end
        end else a_dly--;
      end
    end
  end

  initial begin : monitor
    req_t r;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (data_req && data_addr_ok) begin
          if (req_q.size() == 0) begin
            chk++; err++;
            $display("FAIL unexpected_req: got addr %h expected no request", data_addr);
          end else begin
            r = req_q.pop_front();
            check("req_wr", 32'(data_wr), 32'(r.wr));
            check("req_size", 32'(data_size), 32'(r.size));
            check("req_addr", data_addr, r.addr);
            if (r.wr) check("req_wdata", data_wdata, r.wdata);
          end
        end
        if (mem_done) begin
          if (done_q.size() == 0) begin
            chk++; err++;
            $display("FAIL unexpected_done: got mem_done 1 expected 0");
          end else begin
            e = done_q.pop_front();
            check("mem_rdata", mem_rdata, e);
          end
        end
      end
    end
  end

  task automatic issue(input int op, input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rword,
                       input bit v, input bit cp, input logic [4:0] cpcode, input int a, input int d, input int fl);
    int n = nbytes(op);
    bit mis = n > 1 && (addr % n) != 0;
    bit acc = v && op != 0 && !cp && !mis;
    bit ld = op >= 1 && op <= 5;
    bit ended = 0;
    int stalls = 0;
    req_t r;
    @(posedge clk); #1;
    a_dly = a; d_cfg = d; next_rdata = rword;
    exe_valid = v; mem_op = 4'(op); alu_out = addr; store_data = sd;
    exe_cp0_ex = cp; exe_cp0_excode = cpcode;
    if (acc && (fl == 0 || fl > a)) begin
      r.wr = op >= 6;
      r.size = n == 4 ? 2'd2 : n == 2 ? 2'd1 : 2'd0;
      r.addr = addr & ~32'h3;
      r.wdata = model_wdata(n, sd);
      req_q.push_back(r);
    end
    if (acc && fl == 0) begin
      if (ld) last_rd = model_load(op, addr, rword);
      done_q.push_back(last_rd);
    end
    if (v && mis) bad = addr;
    @(negedge clk);
    check("cp0_ex", 32'(mem_cp0_ex), 32'(cp | (v & mis)));
    if (cp || (v && mis)) check("excode", 32'(mem_cp0_excode), cp ? 32'(cpcode) : ld ? 32'h04 : 32'h05);
    for (int c = 0; c < 40 && !ended; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        exe_valid = 0; exe_cp0_ex = 0; flush = (c == fl);
        @(negedge clk);
      end
      stalls += int'(stall);
      if (fl > 0 && fl <= a && c == fl + 1) check("flush_req_drop", 32'(data_req), 0);
      if (c > 0 && !data_req && !stall && !pend) ended = 1;
    end
    flush = 0;
    if (!ended) begin chk++; err++; $display("FAIL timeout: got busy after 40 cycles expected idle"); end
    check("badvaddr", badvaddr, bad);
    if (fl == 0) check("stall_cycles", stalls, acc ? 2 + a + (d > 0 ? d - 1 : 0) : 0);
    else begin
      @(negedge clk);
      check("cancel_done", 32'(mem_done), 0);
      check("cancel_rdata", mem_rdata, last_rd);
    end
  endtask

  initial begin : stim
    repeat (2) @(negedge clk);
    check("rst_rdata", mem_rdata, 0);
    check("rst_badvaddr", badvaddr, 0);
    check("rst_req", 32'(data_req), 0);
    check("rst_done", 32'(mem_done), 0);
    @(posedge clk); #2 rst = 0;
    issue(5, 32'h100, 0, 32'hDEADBEEF, 1, 0, 0, 1, 1, 0);
    issue(1, 32'h103, 0, 32'h80FFFF7F, 1, 0, 0, 0, 1, 0);
    issue(2, 32'h103, 0, 32'h80FFFF7F, 1, 0, 0, 0, 2, 0);
    issue(3, 32'h102, 0, 32'h80FFFF7F, 1, 0, 0, 1, 0, 0);
    issue(7, 32'h206, 32'h1234ABCD, 32'h0, 1, 0, 0, 0, 1, 0);
    issue(5, 32'h101, 0, 0, 1, 0, 0, 0, 1, 0);
    issue(8, 32'h102, 0, 0, 1, 0, 0, 0, 1, 0);
    issue(5, 32'h100, 0, 0, 1, 1, 5'h0C, 0, 1, 0);
    issue(5, 32'h140, 0, 32'h11112222, 1, 0, 0, 3, 1, 1);
    issue(5, 32'h144, 0, 32'h33334444, 1, 0, 0, 0, 3, 2);
    issue(4, 32'h146, 0, 32'h9876FEDC, 1, 0, 0, 0, 0, 0);
    // reset while the stage waits for a response
    @(posedge clk); #1;
    a_dly = 0; d_cfg = 5; next_rdata = 32'hCAFEF00D;
    exe_valid = 1; mem_op = 4'd5; alu_out = 32'h300;
    req_q.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h300, wdata: 32'h0});
    @(posedge clk); #1 exe_valid = 0;
    @(posedge clk); #2 rst = 1;
    #1;
    check("arst_req", 32'(data_req), 0);
    check("arst_stall", 32'(stall), 0);
    check("arst_rdata", mem_rdata, 0);
    check("arst_badvaddr", badvaddr, 0);
    last_rd = 0; bad = 0;
    @(posedge clk); @(posedge clk); #2 rst = 0;
    issue(5, 32'h304, 0, 32'h0BADC0DE, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 150; i++)
      issue($urandom_range(0, 8), 32'h1000 + $urandom_range(0, 63), $urandom, $urandom,
            $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, 5'($urandom),
            $urandom_range(0, 2), $urandom_range(0, 2), 0);
    repeat (3) @(negedge clk);
    check("req_q_empty", req_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end
endmodule
